// File: rtl/hr_dpwm_pkg.sv
// hr_dpwm_pkg: shared FSM state type, reset timing words and default widths for the HR-DPWM blocks
package hr_dpwm_pkg;
  typedef enum logic [1:0] {IDLE, CALC, CLAMP, ARMED} state_t;
  localparam int DC_LENGTH = 13;
  localparam int DE_BITS = 6;
  localparam int RST_H_ON = 8;
  localparam int RST_L_ON = 16;
  localparam int RST_DT = 8;
endpackage

// File: rtl/hr_timing_calc_if.sv
// hr_timing_calc_if: valid/ready command bus (period, duty, deadtime); master drives the command, slave returns ready
interface hr_timing_calc_if #(parameter int W = hr_dpwm_pkg::DC_LENGTH);
  logic cmd_valid;
  logic cmd_ready;
  logic [W-1:0] cmd_period;
  logic [W-1:0] cmd_duty;
  logic [W-1:0] cmd_deadtime;
  modport master(output cmd_valid, cmd_period, cmd_duty, cmd_deadtime, input cmd_ready);
  modport slave(input cmd_valid, cmd_period, cmd_duty, cmd_deadtime, output cmd_ready);
endinterface

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: synchronises async_in through Sync_stages flops (reset high) and pulses fall_pulse one cycle on a falling edge
module pwm_edge_sync #(parameter int Sync_stages = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall_pulse
);
  logic [Sync_stages-1:0] sync;
  logic dly;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      dly <= 1'b1;
    end else begin
      sync <= {sync[Sync_stages-2:0], async_in};
      dly <= sync[Sync_stages-1];
    end
  end
  assign fall_pulse = dly & ~sync[Sync_stages-1];
endmodule

// File: rtl/hr_timing_calc.sv
// hr_timing_calc: validates/clamps cmd bus commands into H_on/L_on/DeadTime, applied on L_PWM falls with upd_pulse, clamp_flag, err_flag status
module hr_timing_calc
  import hr_dpwm_pkg::*;
#(
  parameter int Nde = 64,
  parameter int DE_bits = DE_BITS,
  parameter int Dc_length = DC_LENGTH,
  parameter int Min_on = 64,
  parameter int Sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hr_timing_calc_if.slave      cmd,
  input  logic                 L_PWM,
  output logic [Dc_length-1:0] H_on,
  output logic [Dc_length-1:0] L_on,
  output logic [Dc_length-1:0] DeadTime,
  output logic                 upd_pulse,
  output logic                 clamp_flag,
  output logic                 err_flag
);
  localparam int AW = Dc_length + 2;
  localparam logic signed [AW-1:0] MIN = AW'(Min_on);
  localparam logic signed [AW-1:0] MIN2 = AW'(2 * Min_on);
  if (Nde != 2 ** DE_bits || Min_on < 1 || Sync_stages < 2) begin : g_bad_cfg
    $error("hr_timing_calc: inconsistent parameters");
  end
  state_t st;
  logic boundary;
  logic [Dc_length-1:0] per_q, duty_q, dt_q, h_p, l_p, dt_p, h_n, l_n;
  logic signed [AW-1:0] avail, hmax, duty_x;
  pwm_edge_sync #(.Sync_stages(Sync_stages)) u_sync (
    .clk(clk), .rst_n(rst_n), .async_in(L_PWM), .fall_pulse(boundary)
  );
  assign duty_x = $signed({2'b00, duty_q});
  assign h_n = duty_x < MIN ? Dc_length'(Min_on) : duty_x > hmax ? hmax[Dc_length-1:0] : duty_q;
  assign l_n = avail[Dc_length-1:0] - h_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cmd.cmd_ready <= 1'b1;
      upd_pulse <= 1'b0;
      clamp_flag <= 1'b0;
      err_flag <= 1'b0;
      H_on <= Dc_length'(RST_H_ON);
      L_on <= Dc_length'(RST_L_ON);
      DeadTime <= Dc_length'(RST_DT);
      per_q <= '0;
      duty_q <= '0;
      dt_q <= '0;
      h_p <= '0;
      l_p <= '0;
      dt_p <= '0;
      avail <= '0;
      hmax <= '0;
    end else begin
      upd_pulse <= 1'b0;
      case (st)
        IDLE: if (cmd.cmd_valid) begin
          per_q <= cmd.cmd_period;
          duty_q <= cmd.cmd_duty;
          dt_q <= cmd.cmd_deadtime;
          clamp_flag <= 1'b0;
          err_flag <= 1'b0;
          cmd.cmd_ready <= 1'b0;
          st <= CALC;
        end
        CALC: begin
          avail <= AW'({2'b00, per_q}) - AW'({dt_q, 1'b0});
          hmax <= AW'({2'b00, per_q}) - AW'({dt_q, 1'b0}) - MIN;
          st <= CLAMP;
        end
        CLAMP: if (avail < MIN2) begin
          err_flag <= 1'b1;
          cmd.cmd_ready <= 1'b1;
          st <= IDLE;
        end else begin
          h_p <= h_n;
          l_p <= l_n;
          dt_p <= dt_q;
          clamp_flag <= h_n != duty_q;
          st <= ARMED;
        end
        ARMED: if (boundary) begin
          H_on <= h_p;
          L_on <= l_p;
          DeadTime <= dt_p;
          upd_pulse <= 1'b1;
          cmd.cmd_ready <= 1'b1;
          st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hr_timing_calc.sv
// tb_hr_timing_calc: randomized and directed checks of hr_timing_calc against an arithmetic reference model
module tb_hr_timing_calc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic L_PWM = 1'b1;
  logic [12:0] H_on, L_on, DeadTime;
  logic upd_pulse, clamp_flag, err_flag;
  int total = 0;
  int bad = 0;
  int exp_h = 8, exp_l = 16, exp_dt = 8;
  int pend_h, pend_l, pend_dt;
  bit pend_valid = 0;
  bit mdl_err, mdl_clamp;
  hr_timing_calc_if #(.W(13)) bus ();
  hr_timing_calc dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus.slave), .L_PWM(L_PWM),
    .H_on(H_on), .L_on(L_on), .DeadTime(DeadTime),
    .upd_pulse(upd_pulse), .clamp_flag(clamp_flag), .err_flag(err_flag)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag);
    chk({tag, ".h_on"}, H_on, exp_h);
    chk({tag, ".l_on"}, L_on, exp_l);
    chk({tag, ".dt"}, DeadTime, exp_dt);
  endtask
  task automatic model_cmd(input int p, input int d, input int t);
    int av, h;
    av = p - 2 * t;
    mdl_err = av < 128;
    mdl_clamp = 0;
    if (!mdl_err) begin
      h = d < 64 ? 64 : (d > av - 64 ? av - 64 : d);
      pend_h = h;
      pend_l = av - h;
      pend_dt = t;
      pend_valid = 1;
      mdl_clamp = h != d;
    end
  endtask
  task automatic check_after_calc(input string tag);
    chk({tag, ".err"}, err_flag, mdl_err);
    chk({tag, ".clamp"}, clamp_flag, mdl_clamp);
    chk({tag, ".ready"}, bus.cmd_ready, mdl_err);
    chk_out(tag);
  endtask
  task automatic send(input string tag, input int p, input int d, input int t, input int lead);
    int n;
    @(posedge clk);
    if (lead > 0) begin
      #1 L_PWM = 1'b0;
      repeat (lead - 1) @(posedge clk);
    end
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_period = 13'(p);
    bus.cmd_duty = 13'(d);
    bus.cmd_deadtime = 13'(t);
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready_wait"}, n < 20, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    model_cmd(p, d, t);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_after_calc(tag);
  endtask
  task automatic fall(input string tag);
    int lat, cnt;
    lat = 0;
    cnt = 0;
    @(posedge clk);
    #1 L_PWM = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd_pulse) begin
        cnt++;
        if (lat == 0) lat = i;
      end
    end
    if (pend_valid) begin
      chk({tag, ".latency"}, lat, 3);
      chk({tag, ".pulses"}, cnt, 1);
      exp_h = pend_h;
      exp_l = pend_l;
      exp_dt = pend_dt;
      pend_valid = 0;
    end else chk({tag, ".pulses"}, cnt, 0);
    chk_out(tag);
    @(posedge clk);
    #1 L_PWM = 1'b1;
    repeat (4) @(posedge clk);
  endtask
  task automatic quiet(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (upd_pulse) cnt++;
    end
    chk({tag, ".pulses"}, cnt, 0);
    chk_out(tag);
  endtask
  initial begin
    int lat, early;
    bus.cmd_valid = 1'b0;
    bus.cmd_period = '0;
    bus.cmd_duty = '0;
    bus.cmd_deadtime = '0;
    for (int i = 0; i < 4; i++) #7 L_PWM = ~L_PWM;
    @(negedge clk);
    chk_out("reset");
    chk("reset.ready", bus.cmd_ready, 1);
    chk("reset.flags", {upd_pulse, clamp_flag, err_flag}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(posedge clk);
      #1 L_PWM = ~L_PWM;
    end
    quiet("post_reset", 8);
    send("nominal", 1000, 400, 50, 0);
    fall("nominal_upd");
    send("clamp_lo", 1000, 20, 50, 0);
    fall("clamp_lo_upd");
    send("clamp_hi", 1000, 990, 50, 0);
    fall("clamp_hi_upd");
    send("infeasible", 200, 100, 50, 0);
    fall("infeasible_f1");
    fall("infeasible_f2");
    send("overflow", 8191, 100, 8191, 0);
    fall("overflow_f");
    send("hs_first", 1000, 400, 50, 0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_period = 13'd600;
    bus.cmd_duty = 13'd200;
    bus.cmd_deadtime = 13'd40;
    repeat (3) begin
      @(negedge clk);
      chk("hs.held_ready", bus.cmd_ready, 0);
    end
    @(posedge clk);
    #1 L_PWM = 1'b0;
    lat = 0;
    early = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd_pulse) lat = i;
      else if (bus.cmd_ready) early++;
    end
    chk("hs.latency", lat, 3);
    chk("hs.ready_early", early, 0);
    chk("hs.ready_after_upd", bus.cmd_ready, 1);
    exp_h = pend_h;
    exp_l = pend_l;
    exp_dt = pend_dt;
    pend_valid = 0;
    chk_out("hs.first_out");
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    model_cmd(600, 200, 40);
    @(negedge clk);
    chk("hs.accepted", bus.cmd_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_after_calc("hs_second");
    @(posedge clk);
    #1 L_PWM = 1'b1;
    repeat (4) @(posedge clk);
    fall("hs_second_upd");
    send("edge_in_calc", 1500, 700, 30, 2);
    @(posedge clk);
    #1 L_PWM = 1'b1;
    quiet("edge_in_calc_wait", 6);
    fall("edge_in_calc_upd");
    send("edge_at_accept", 900, 300, 20, 3);
    @(posedge clk);
    #1 L_PWM = 1'b1;
    quiet("edge_at_accept_wait", 6);
    fall("edge_at_accept_upd");
    send("rst_armed", 1000, 400, 50, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_h = 8;
    exp_l = 16;
    exp_dt = 8;
    pend_valid = 0;
    chk_out("rst_armed.now");
    chk("rst_armed.ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fall("rst_armed_fall");
    for (int k = 0; k < 24; k++) begin
      int p, d, t;
      p = $urandom_range(8191, 0);
      t = $urandom_range(600, 0);
      d = $urandom_range(8191, 0);
      send("rand", p, d, t, 0);
      if (!mdl_err) fall("rand_upd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
